// File: rtl/bank_cmd_scheduler.sv
// Single-bank LPDDR command scheduler: open-page policy, tRCD/tRP/tRFC/burst spacing
// and periodic auto-refresh, driving one-cycle ACT/RD/WR/PR/REF strobes.
module bank_cmd_scheduler #(
  parameter int unsigned T_RCD  = 17,
  parameter int unsigned T_RP   = 17,
  parameter int unsigned T_RFC  = 34,
  parameter int unsigned T_REFI = 7800,
  parameter int unsigned BURST  = 8,
  parameter int unsigned ROW_W  = 16,
  parameter int unsigned COL_W  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [ROW_W-1:0] req_row_i,
  input  logic [COL_W-1:0] req_col_i,
  output logic             cmd_act_o,
  output logic             cmd_rd_o,
  output logic             cmd_wr_o,
  output logic             cmd_pr_o,
  output logic             cmd_ref_o,
  output logic [ROW_W-1:0] cmd_row_o,
  output logic [COL_W-1:0] cmd_col_o,
  output logic             ref_pend_o,
  output logic             busy_o
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_ACT        = 4'd1,
    S_RCD_WAIT   = 4'd2,
    S_COL        = 4'd3,
    S_BURST_WAIT = 4'd4,
    S_ACTIVE     = 4'd5,
    S_PRE        = 4'd6,
    S_RP_WAIT    = 4'd7,
    S_REF        = 4'd8,
    S_RFC_WAIT   = 4'd9
  } state_e;

  // The strobe cycle itself counts toward each timing window, hence N-1.
  localparam logic [7:0]  RCD_LD   = 8'(T_RCD - 1);
  localparam logic [7:0]  RP_LD    = 8'(T_RP - 1);
  localparam logic [7:0]  RFC_LD   = 8'(T_RFC - 1);
  localparam logic [7:0]  BURST_LD = 8'(BURST - 1);
  localparam logic [15:0] REFI_LD  = 16'(T_REFI);

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [15:0]        refi_q, refi_d;
  logic               ref_pend_q, ref_pend_d;
  logic               ref_intent_q, ref_intent_d;
  logic               row_open_q, row_open_d;
  logic [ROW_W-1:0]   open_row_q, open_row_d;
  logic               lat_we_q, lat_we_d;
  logic [ROW_W-1:0]   lat_row_q, lat_row_d;
  logic [COL_W-1:0]   lat_col_q, lat_col_d;
  logic               cmd_act_q, cmd_rd_q, cmd_wr_q, cmd_pr_q, cmd_ref_q;
  logic [ROW_W-1:0]   cmd_row_q;
  logic [COL_W-1:0]   cmd_col_q;

  logic               accept_s;
  logic               cnt_zero_s;
  logic               row_hit_s;
  logic               refi_expire_s;
  logic               ref_clear_s;
  logic               we_src_s;
  logic [ROW_W-1:0]   row_src_s;
  logic [COL_W-1:0]   col_src_s;

  assign req_ready_o   = ((state_q == S_IDLE) || (state_q == S_ACTIVE)) && !ref_pend_q;
  assign accept_s      = req_valid_i && req_ready_o;
  assign cnt_zero_s    = (cnt_q == 8'd0);
  assign row_hit_s     = row_open_q && (req_row_i == open_row_q);
  assign refi_expire_s = (refi_q == 16'd1);
  assign ref_clear_s   = ((state_q == S_REF) || (state_q == S_RFC_WAIT)) && cnt_zero_s;

  // A request accepted this cycle feeds the next strobe directly; otherwise use the latched copy.
  assign we_src_s  = accept_s ? req_we_i  : lat_we_q;
  assign row_src_s = accept_s ? req_row_i : lat_row_q;
  assign col_src_s = accept_s ? req_col_i : lat_col_q;

  assign cmd_act_o  = cmd_act_q;
  assign cmd_rd_o   = cmd_rd_q;
  assign cmd_wr_o   = cmd_wr_q;
  assign cmd_pr_o   = cmd_pr_q;
  assign cmd_ref_o  = cmd_ref_q;
  assign cmd_row_o  = cmd_row_q;
  assign cmd_col_o  = cmd_col_q;
  assign ref_pend_o = ref_pend_q;
  assign busy_o     = (state_q != S_IDLE);

  always_comb begin
    state_d      = state_q;
    ref_intent_d = ref_intent_q;
    row_open_d   = row_open_q;
    open_row_d   = open_row_q;
    case (state_q)
      S_IDLE: begin
        if (ref_pend_q) begin
          state_d = S_REF;
        end else if (accept_s) begin
          state_d = S_ACT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACT: begin
        row_open_d = 1'b1;
        open_row_d = lat_row_q;
        state_d    = cnt_zero_s ? S_COL : S_RCD_WAIT;
      end
      S_RCD_WAIT:          state_d = cnt_zero_s ? S_COL : S_RCD_WAIT;
      S_COL, S_BURST_WAIT: state_d = cnt_zero_s ? S_ACTIVE : S_BURST_WAIT;
      S_ACTIVE: begin
        if (ref_pend_q) begin
          state_d      = S_PRE;
          ref_intent_d = 1'b1;
        end else if (accept_s) begin
          if (row_hit_s) begin
            state_d = S_COL;
          end else begin
            state_d      = S_PRE;
            ref_intent_d = 1'b0;
          end
        end else begin
          state_d = S_ACTIVE;
        end
      end
      S_PRE, S_RP_WAIT: begin
        row_open_d = 1'b0;
        if (cnt_zero_s) begin
          state_d = ref_intent_q ? S_REF : S_ACT;
        end else begin
          state_d = S_RP_WAIT;
        end
      end
      S_REF, S_RFC_WAIT:   state_d = cnt_zero_s ? S_IDLE : S_RFC_WAIT;
      default:             state_d = S_IDLE;
    endcase
  end

  // Strobe states last exactly one cycle, so landing in one always means a fresh load.
  always_comb begin
    case (state_d)
      S_ACT:   cnt_d = RCD_LD;
      S_COL:   cnt_d = BURST_LD;
      S_PRE:   cnt_d = RP_LD;
      S_REF:   cnt_d = RFC_LD;
      default: cnt_d = cnt_zero_s ? 8'd0 : (cnt_q - 8'd1);
    endcase
  end

  // An expiry while a refresh is already owed is dropped rather than queued.
  always_comb begin
    refi_d = refi_expire_s ? REFI_LD : (refi_q - 16'd1);
    if (refi_expire_s && !ref_pend_q) begin
      ref_pend_d = 1'b1;
    end else if (ref_clear_s) begin
      ref_pend_d = 1'b0;
    end else begin
      ref_pend_d = ref_pend_q;
    end
    if (accept_s) begin
      lat_we_d  = req_we_i;
      lat_row_d = req_row_i;
      lat_col_d = req_col_i;
    end else begin
      lat_we_d  = lat_we_q;
      lat_row_d = lat_row_q;
      lat_col_d = lat_col_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      refi_q       <= REFI_LD;
      ref_pend_q   <= 1'b0;
      ref_intent_q <= 1'b0;
      row_open_q   <= 1'b0;
      open_row_q   <= '0;
      lat_we_q     <= 1'b0;
      lat_row_q    <= '0;
      lat_col_q    <= '0;
      cmd_act_q    <= 1'b0;
      cmd_rd_q     <= 1'b0;
      cmd_wr_q     <= 1'b0;
      cmd_pr_q     <= 1'b0;
      cmd_ref_q    <= 1'b0;
      cmd_row_q    <= '0;
      cmd_col_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      refi_q       <= refi_d;
      ref_pend_q   <= ref_pend_d;
      ref_intent_q <= ref_intent_d;
      row_open_q   <= row_open_d;
      open_row_q   <= open_row_d;
      lat_we_q     <= lat_we_d;
      lat_row_q    <= lat_row_d;
      lat_col_q    <= lat_col_d;
      cmd_act_q    <= (state_d == S_ACT);
      cmd_rd_q     <= (state_d == S_COL) && !we_src_s;
      cmd_wr_q     <= (state_d == S_COL) && we_src_s;
      cmd_pr_q     <= (state_d == S_PRE);
      cmd_ref_q    <= (state_d == S_REF);
      if (state_d == S_ACT) begin
        cmd_row_q <= row_src_s;
      end
      if (state_d == S_COL) begin
        cmd_col_q <= col_src_s;
      end
    end
  end

endmodule

// File: tb/tb_bank_cmd_scheduler.sv
// Randomised and directed bench for bank_cmd_scheduler, checked every cycle against a
// schedule model that computes strobe times from the timing rules by arithmetic.
module tb_bank_cmd_scheduler;

  localparam int T_RCD  = 17;
  localparam int T_RP   = 17;
  localparam int T_RFC  = 34;
  localparam int T_REFI = 100;
  localparam int BURST  = 8;
  localparam int K_ACT  = 1;
  localparam int K_RD   = 2;
  localparam int K_WR   = 3;
  localparam int K_PR   = 4;
  localparam int K_REF  = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [15:0] req_row = 16'd0;
  logic [9:0]  req_col = 10'd0;
  logic        cmd_act, cmd_rd, cmd_wr, cmd_pr, cmd_ref;
  logic [15:0] cmd_row;
  logic [9:0]  cmd_col;
  logic        ref_pend, busy;

  int checks = 0;
  int errors = 0;

  // Model: cycle index since reset, owed refresh, open row and the cycle the scheduler frees up.
  int c;
  bit m_pend;
  bit m_open;
  int m_open_row;
  int avail;
  int clr_at;
  int e_row;
  int e_col;
  int ev_kind[int];
  int ev_row[int];
  int ev_col[int];

  bank_cmd_scheduler #(
    .T_RCD(T_RCD), .T_RP(T_RP), .T_RFC(T_RFC), .T_REFI(T_REFI), .BURST(BURST),
    .ROW_W(16), .COL_W(10)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_row_i(req_row), .req_col_i(req_col),
    .cmd_act_o(cmd_act), .cmd_rd_o(cmd_rd), .cmd_wr_o(cmd_wr), .cmd_pr_o(cmd_pr),
    .cmd_ref_o(cmd_ref), .cmd_row_o(cmd_row), .cmd_col_o(cmd_col),
    .ref_pend_o(ref_pend), .busy_o(busy)
  );

  always #5 clk = ~clk;

  function automatic bit m_ready();
    return (c >= avail) && !m_pend;
  endfunction

  function automatic logic [33:0] exp_vec();
    int k;
    k = ev_kind.exists(c) ? ev_kind[c] : 0;
    return {m_ready(), !((c >= avail) && !m_open), m_pend,
            1'(k == K_ACT), 1'(k == K_RD), 1'(k == K_WR), 1'(k == K_PR), 1'(k == K_REF),
            16'(e_row), 10'(e_col)};
  endfunction

  function automatic logic [33:0] obs_vec();
    return {req_ready, busy, ref_pend, cmd_act, cmd_rd, cmd_wr, cmd_pr, cmd_ref, cmd_row, cmd_col};
  endfunction

  task automatic sched(input int t, input int k, input int r, input int col);
    ev_kind[t] = k;
    ev_row[t]  = r;
    ev_col[t]  = col;
  endtask

  task automatic model_reset();
    c = 0; m_pend = 1'b0; m_open = 1'b0; m_open_row = 0;
    avail = 0; clr_at = -1; e_row = 0; e_col = 0;
    ev_kind.delete(); ev_row.delete(); ev_col.delete();
  endtask

  task automatic model_advance(input bit v, input bit we, input int row, input int col);
    bit acc;
    int t;
    acc = v && m_ready();
    if (c >= avail) begin
      if (m_pend) begin
        t = c + 1;
        if (m_open) begin
          sched(t, K_PR, 0, 0);
          t = t + T_RP;
        end
        sched(t, K_REF, 0, 0);
        avail = t + T_RFC;
        clr_at = avail;
        m_open = 1'b0;
      end else if (acc) begin
        t = c + 1;
        if (!(m_open && row == m_open_row)) begin
          if (m_open) begin
            sched(t, K_PR, 0, 0);
            t = t + T_RP;
          end
          sched(t, K_ACT, row, 0);
          t = t + T_RCD;
          m_open = 1'b1;
          m_open_row = row;
        end
        sched(t, we ? K_WR : K_RD, 0, col);
        avail = t + BURST;
      end
    end
    if ((((c + 1) % T_REFI) == 0) && !m_pend) m_pend = 1'b1;
    else if ((c + 1) == clr_at) m_pend = 1'b0;
    c++;
    if (ev_kind.exists(c)) begin
      if (ev_kind[c] == K_ACT) e_row = ev_row[c];
      else if (ev_kind[c] == K_RD || ev_kind[c] == K_WR) e_col = ev_col[c];
    end
  endtask

  task automatic step(input bit v, input bit we, input int row, input int col);
    req_valid = v;
    req_we    = we;
    req_row   = 16'(row);
    req_col   = 10'(col);
    model_advance(v, we, row, col);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || ref_pend !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got ready=%b busy=%b pend=%b want 1 0 0", req_ready, busy, ref_pend);
    end
    checks++;
    if (dut.refi_q !== 16'(T_REFI)) begin
      errors++;
      $display("FAIL reset_refi: got %0d want %0d", dut.refi_q, T_REFI);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_vec cyc=%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      step(1'b0, 1'b0, 0, 0);
    end
  endtask

  task automatic test_read_idle();
    do_reset();
    step(1'b1, 1'b0, 5, 3);
    while (c < 26) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL t1_vec cyc=%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (c == 1) begin
        checks++;
        if (cmd_act !== 1'b1 || cmd_row !== 16'd5 || busy !== 1'b1) begin
          errors++;
          $display("FAIL t1_act: got act=%b row=%0d busy=%b want 1 5 1", cmd_act, cmd_row, busy);
        end
      end
      if (c == 18) begin
        checks++;
        if (cmd_rd !== 1'b1 || cmd_col !== 10'd3) begin
          errors++;
          $display("FAIL t1_rd: got rd=%b col=%0d want 1 3", cmd_rd, cmd_col);
        end
      end
      step(1'b0, 1'b0, 0, 0);
    end
  endtask

  task automatic test_write_hit();
    bit done;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL t2_active: got ready=%b busy=%b want 1 1", req_ready, busy);
    end
    step(1'b1, 1'b1, 5, 9);
    while (c < 35) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL t2_vec cyc=%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (c == 27) begin
        checks++;
        if (cmd_wr !== 1'b1 || cmd_col !== 10'd9 || cmd_act !== 1'b0 || cmd_pr !== 1'b0) begin
          errors++;
          $display("FAIL t2_wr: got wr=%b col=%0d act=%b pr=%b want 1 9 0 0", cmd_wr, cmd_col, cmd_act, cmd_pr);
        end
      end
      step(1'b0, 1'b0, 0, 0);
    end
    done = 1'b0;
    while (c < 44) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL t2b_vec cyc=%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (c == 36) begin
        checks++;
        if (cmd_rd !== 1'b1 || cmd_col !== 10'd11) begin
          errors++;
          $display("FAIL t2_second_hit: got rd=%b col=%0d want 1 11", cmd_rd, cmd_col);
        end
      end
      if (!done && m_ready()) begin
        done = 1'b1;
        step(1'b1, 1'b0, 5, 11);
      end else begin
        step(!done, 1'b0, 5, 11);
      end
    end
  endtask

  task automatic test_miss();
    step(1'b1, 1'b0, 7, 4);
    while (c < 87) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL t3_vec cyc=%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (c == 45 || c == 62 || c == 79) begin
        checks++;
        if ((c == 45 && cmd_pr !== 1'b1) || (c == 62 && (cmd_act !== 1'b1 || cmd_row !== 16'd7)) ||
            (c == 79 && (cmd_rd !== 1'b1 || cmd_col !== 10'd4))) begin
          errors++;
          $display("FAIL t3_miss cyc=%0d: got pr=%b act=%b rd=%b row=%0d col=%0d", c, cmd_pr, cmd_act, cmd_rd, cmd_row, cmd_col);
        end
      end
      step(1'b0, 1'b0, 0, 0);
    end
  endtask

  task automatic test_refresh();
    while (c < 160) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL t4_vec cyc=%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (c == 100) begin
        checks++;
        if (ref_pend !== 1'b1 || req_ready !== 1'b0) begin
          errors++;
          $display("FAIL t4_pend: got pend=%b ready=%b want 1 0", ref_pend, req_ready);
        end
      end
      if (c == 118) begin
        checks++;
        if (cmd_ref !== 1'b1) begin
          errors++;
          $display("FAIL t4_ref: got ref=%b want 1", cmd_ref);
        end
      end
      if (c == 152) begin
        checks++;
        if (ref_pend !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
          errors++;
          $display("FAIL t4_done: got pend=%b busy=%b ready=%b want 0 0 1", ref_pend, busy, req_ready);
        end
      end
      step((c >= 100) && (c <= 140), 1'b0, 5, 1);
    end
  endtask

  task automatic test_collide();
    do_reset();
    while (c < 99) step(1'b0, 1'b0, 0, 0);
    checks++;
    if (req_ready !== 1'b1 || ref_pend !== 1'b0) begin
      errors++;
      $display("FAIL t5_pre: got ready=%b pend=%b want 1 0", req_ready, ref_pend);
    end
    step(1'b1, 1'b1, 3, 2);
    while (c < 180) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL t5_vec cyc=%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      checks++;
      if ($countones({cmd_act, cmd_rd, cmd_wr, cmd_pr, cmd_ref}) > 1) begin
        errors++;
        $display("FAIL t5_onehot cyc=%0d: got strobes %b want at most one", c, {cmd_act, cmd_rd, cmd_wr, cmd_pr, cmd_ref});
      end
      if (c == 100 || c == 117 || c == 126 || c == 143) begin
        checks++;
        if ((c == 100 && (cmd_act !== 1'b1 || ref_pend !== 1'b1)) || (c == 117 && cmd_wr !== 1'b1) ||
            (c == 126 && cmd_pr !== 1'b1) || (c == 143 && cmd_ref !== 1'b1)) begin
          errors++;
          $display("FAIL t5_order cyc=%0d: got act=%b wr=%b pr=%b ref=%b pend=%b", c, cmd_act, cmd_wr, cmd_pr, cmd_ref, ref_pend);
        end
      end
      step(1'b0, 1'b0, 0, 0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b1, 1'b0, 5, 3);
    while (c < 5) step(1'b0, 1'b0, 0, 0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL t6_busy_before: got %b want 1", busy);
    end
    do_reset();
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || dut.refi_q !== 16'(T_REFI)) begin
      errors++;
      $display("FAIL t6_after: got ready=%b busy=%b refi=%0d want 1 0 %0d", req_ready, busy, dut.refi_q, T_REFI);
    end
    for (int i = 0; i < 30; i++) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL t6_vec cyc=%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      step(1'b0, 1'b0, 0, 0);
    end
  endtask

  task automatic test_random();
    bit r_v, r_we, acc;
    int r_row, r_col;
    do_reset();
    r_v = 1'b0; r_we = 1'b0; r_row = 0; r_col = 0;
    for (int i = 0; i < 4000; i++) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rand_vec cyc=%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      checks++;
      if ($countones({cmd_act, cmd_rd, cmd_wr, cmd_pr, cmd_ref}) > 1) begin
        errors++;
        $display("FAIL rand_onehot cyc=%0d: got strobes %b want at most one", c, {cmd_act, cmd_rd, cmd_wr, cmd_pr, cmd_ref});
      end
      if (!r_v && ($urandom_range(0, 1) == 1)) begin
        r_v   = 1'b1;
        r_we  = 1'($urandom_range(0, 1));
        r_row = int'($urandom_range(0, 3));
        r_col = int'($urandom_range(0, 1023));
      end
      acc = r_v && m_ready();
      step(r_v, r_we, r_row, r_col);
      if (acc) r_v = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_read_idle();
    test_write_hit();
    test_miss();
    test_refresh();
    test_collide();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
